pi_ctrl: RTL and testbench
==========================

# pi_ctrl

Priority-interrupt (PI) controller for the KS-10 CPU. Collects the seven bus PI request lines, including the APR device's own `bus_pi_req_out`, and the program-set requests. It qualifies them against the PI-system and per-level enables and against the levels already in progress. It then presents the single highest-priority eligible level to the microcode through a request/acknowledge handshake. It also maintains the in-progress (PIH) stack that is unwound by interrupt dismiss, and supplies the CONI PI status word.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `clken`  in  1  clock enable; all state updates qualified by it
- `dp`  in  [0:35]  datapath; CONO PI data
- `pi_cono`  in  1  decoded microcode strobe: load CONO PI from `dp`
- `pi_ack`  in  1  microcode accepts the presented level
- `pi_dismiss`  in  1  microcode dismisses the current interrupt
- `bus_pi_req_in`  in  [1:7]  device requests; level 1 is highest priority
- `pi_int_req`  out  1  interrupt request to the microcode (registered)
- `pi_new_lev`  out  [0:2]  level being requested, 1–7 (registered)
- `pi_stat`  out  [0:36-1]  CONI PI word; all bits not listed below read 0
  - bits 11–17: PIR[1:7]
  - bits 21–27: PIH[1:7]
  - bit 28: PI ON
  - bits 29–35: PIE[1:7]

## Operation
- State registers:
  - `pi_on`
  - `pie[1:7]`: level enables
  - `pir[1:7]`: program requests
  - `pih[1:7]`: in progress
  - FSM: IDLE, REQ
- CONO PI (`clken & pi_cono`), with field L = `dp[29:35]`:
  - Bit 23 clears `pi_on`, `pie`, `pir` and `pih`, and forces IDLE. It overrides all other bits and any simultaneous ack or dismiss.
  - Bit 24: `pir |= L`.
  - Bit 25: `pie |= L`.
  - Bit 26: `pie &= ~L`.
  - Bit 27: clear `pi_on`.
  - Bit 28: set `pi_on`.
  - Precedence: if 25 and 26 are both set, 26 wins. If 27 and 28 are both set, 27 wins.
- Active level n is defined as `pi_on & ((pie[n] & bus_pi_req_in[n]) | pir[n])`. Program requests ignore `pie`.
- Best level B is the lowest-numbered active level.
- Eligibility: B is eligible iff no `pih` bit is set, or B < the lowest-numbered set `pih` bit. A level equal to or below the current PIH level is held off.
- FSM, evaluated each `clken` cycle:
  - **IDLE:** if an eligible B exists, go to REQ, set `pi_int_req`=1 and load `pi_new_lev`=B.
  - **REQ:** each cycle, reload `pi_new_lev` with the current eligible B, which may rise in priority. If none is eligible, go to IDLE and clear `pi_int_req` and `pi_new_lev`.
  - **REQ & `pi_ack`:** set `pih[pi_new_lev]`, clear `pir[pi_new_lev]`, go to IDLE and clear `pi_int_req`. The ack acts on the level presented before this edge.
  - **`pi_ack` in IDLE:** ignored.
- Dismiss (`clken & pi_dismiss`): clear the lowest-numbered set `pih` bit. No effect if `pih`==0.
- Dismiss and ack in the same cycle: dismiss is computed on the old `pih`, the ack's bit is then set, and both apply.
- CONO without bit 23 in the same cycle as an ack: both apply. PIR set-by-CONO and clear-by-ack on the same bit resolve to clear.
- `pi_stat` is combinational from the registers.

## Timing
- Reset: all registers 0, FSM IDLE, `pi_int_req`=0, `pi_new_lev`=0, `pi_stat`=0.
- `clken` low: all state frozen and inputs ignored.
- Request latency: an input or register change makes B eligible, and `pi_int_req` rises on the next `clken` edge (1 enabled cycle).
- After an ack, `pi_int_req` is low for at least 1 enabled cycle. Re-request of a higher level occurs no sooner than the second enabled edge after the ack.
- Device requests are level-sensitive and not latched: a request dropped before the ack withdraws `pi_int_req` on the next enabled edge.
- `rst` asserted mid-handshake returns everything to reset values asynchronously.

## Test plan
- Reset, then CONO PI with bit 28 and bit 25 on L=0b0000100 (level 5), then `bus_pi_req_in[5]`=1 → `pi_int_req`=1 and `pi_new_lev`=5 one enabled cycle later; ack → `pih`=level 5, `pi_stat[25]`=1, `pi_int_req`=0.
- With PIH level 5 held, raise level 6 → no request. Raise level 3 → request with `pi_new_lev`=3. Ack, then dismiss twice → `pih` clears level 3 first, then level 5.
- In REQ with level 5 presented, raise level 2 → `pi_new_lev` updates to 2 before the ack. Drop all requests → `pi_int_req`=0 next enabled cycle.
- CONO bit 24 with L=level 7 and `pie`=0 → request level 7; ack clears `pir[7]` and `pi_stat[17]`=0.
- Ack together with CONO bit 23 → `pih`=0, `pir`=0, `pie`=0, `pi_on`=0, state IDLE. Separately, CONO with bits 25 and 26 on the same L → `pie` bits cleared.
- Toggle `clken` low during REQ with ack asserted → no state change. Assert `rst` in REQ → all outputs 0 immediately.

Source files
------------

// File: rtl/pi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pi_ctrl
//  Description : KS-10 priority-interrupt controller. Qualifies bus and
//                program requests against PI ON, level enables and the
//                in-progress (PIH) stack, presents the best eligible level to
//                the microcode via req/ack, and builds the CONI PI word.
//  Revision    : 1.0  initial release
// ============================================================================
module pi_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic [0:35] dp,
  input  logic        pi_cono,
  input  logic        pi_ack,
  input  logic        pi_dismiss,
  input  logic [1:7]  bus_pi_req_in,
  output logic        pi_int_req,
  output logic [0:2]  pi_new_lev,
  output logic [0:35] pi_stat
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_pi_on;
  logic [1:7] r_pie;
  logic [1:7] r_pir;
  logic [1:7] r_pih;

  logic [1:7] w_lvl_sel;
  logic [1:7] w_active;
  logic [0:2] w_best;
  logic       w_best_vld;
  logic [0:2] w_pih_lev;
  logic       w_pih_vld;
  logic       w_elig;
  logic       w_ack;
  logic [1:7] w_pih_nxt;
  logic [1:7] w_pir_nxt;
  logic [1:7] w_pie_nxt;
  logic       w_on_nxt;
  logic       w_dp_unused;

  // Only the CONO control bits and the level field are meaningful here.
  assign w_dp_unused = ^dp[0:22];

  assign w_lvl_sel = dp[29:35];

  // Program requests bypass the per-level enables; everything needs PI ON.
  assign w_active = {7{r_pi_on}} & ((r_pie & bus_pi_req_in) | r_pir);

  // An ack only means something while a level is being presented.
  assign w_ack = (r_state == ST_REQ) & pi_ack;

  // Priority encoders: lowest-numbered active level and lowest held level.
  always_comb begin
    w_best     = '0;
    w_best_vld = 1'b0;
    w_pih_lev  = '0;
    w_pih_vld  = 1'b0;
    for (int n = 7; n >= 1; n--) begin
      if (w_active[n]) begin
        w_best     = 3'(n);
        w_best_vld = 1'b1;
      end
      if (r_pih[n]) begin
        w_pih_lev = 3'(n);
        w_pih_vld = 1'b1;
      end
    end
  end

  // A level at or below the one currently in progress is held off.
  assign w_elig = w_best_vld & (~w_pih_vld | (w_best < w_pih_lev));

  // Next-state of the PI registers for a non-clearing enabled cycle.
  always_comb begin
    w_pih_nxt = r_pih;
    w_pir_nxt = r_pir;
    w_pie_nxt = r_pie;
    w_on_nxt  = r_pi_on;
    // Dismiss works on the stack as it was before any ack this cycle.
    if (pi_dismiss && w_pih_vld) begin
      for (int n = 1; n <= 7; n++) begin
        if (w_pih_lev == 3'(n)) w_pih_nxt[n] = 1'b0;
      end
    end
    if (pi_cono && dp[24]) w_pir_nxt = w_pir_nxt | w_lvl_sel;
    if (pi_cono && dp[26])      w_pie_nxt = r_pie & ~w_lvl_sel;
    else if (pi_cono && dp[25]) w_pie_nxt = r_pie | w_lvl_sel;
    if (pi_cono && dp[27])      w_on_nxt = 1'b0;
    else if (pi_cono && dp[28]) w_on_nxt = 1'b1;
    // Ack acts on the presented level; its PIR clear beats a CONO set.
    if (w_ack) begin
      for (int n = 1; n <= 7; n++) begin
        if (pi_new_lev == 3'(n)) begin
          w_pih_nxt[n] = 1'b1;
          w_pir_nxt[n] = 1'b0;
        end
      end
    end
  end

  // Register update and request/acknowledge FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pi_on    <= 1'b0;
      r_pie      <= '0;
      r_pir      <= '0;
      r_pih      <= '0;
      pi_int_req <= 1'b0;
      pi_new_lev <= '0;
    end else if (clken) begin
      if (pi_cono && dp[23]) begin
        r_state    <= ST_IDLE;
        r_pi_on    <= 1'b0;
        r_pie      <= '0;
        r_pir      <= '0;
        r_pih      <= '0;
        pi_int_req <= 1'b0;
        pi_new_lev <= '0;
      end else begin
        r_pi_on <= w_on_nxt;
        r_pie   <= w_pie_nxt;
        r_pir   <= w_pir_nxt;
        r_pih   <= w_pih_nxt;
        case (r_state)
          ST_IDLE: begin
            if (w_elig) begin
              r_state    <= ST_REQ;
              pi_int_req <= 1'b1;
              pi_new_lev <= w_best;
            end
          end
          ST_REQ: begin
            if (pi_ack || !w_elig) begin
              r_state    <= ST_IDLE;
              pi_int_req <= 1'b0;
              pi_new_lev <= '0;
            end else begin
              pi_new_lev <= w_best;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            pi_int_req <= 1'b0;
            pi_new_lev <= '0;
          end
        endcase
      end
    end
  end

  // CONI PI status word assembled straight from the registers.
  always_comb begin
    pi_stat        = '0;
    pi_stat[11:17] = r_pir;
    pi_stat[21:27] = r_pih;
    pi_stat[28]    = r_pi_on;
    pi_stat[29:35] = r_pie;
  end

endmodule
`default_nettype wire

// File: tb/tb_pi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_ctrl
//  Description : Self-checking bench for pi_ctrl: directed scenarios followed
//                by randomized traffic, all checked against a level-based
//                behavioural model of the PI system.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pi_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken;
  logic [0:35] dp;
  logic        pi_cono;
  logic        pi_ack;
  logic        pi_dismiss;
  logic [1:7]  bus_pi_req_in;
  logic        pi_int_req;
  logic [0:2]  pi_new_lev;
  logic [0:35] pi_stat;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit       m_on;
  bit [1:7] m_pie, m_pir, m_pih;
  bit       m_req;
  int       m_lev;

  pi_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .clken         (clken),
    .dp            (dp),
    .pi_cono       (pi_cono),
    .pi_ack        (pi_ack),
    .pi_dismiss    (pi_dismiss),
    .bus_pi_req_in (bus_pi_req_in),
    .pi_int_req    (pi_int_req),
    .pi_new_lev    (pi_new_lev),
    .pi_stat       (pi_stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input bit [1:7] v);
    for (int n = 1; n <= 7; n++) if (v[n]) return n;
    return 0;
  endfunction

  // Highest-priority level that may interrupt now, or 0 if none.
  function automatic int best_eligible();
    bit [1:7] act;
    int b, h;
    for (int n = 1; n <= 7; n++)
      act[n] = m_on && ((m_pie[n] && bus_pi_req_in[n] === 1'b1) || m_pir[n]);
    b = lowest(act);
    h = lowest(m_pih);
    if (b != 0 && (h == 0 || b < h)) return b;
    return 0;
  endfunction

  function automatic logic [0:35] exp_stat();
    logic [0:35] s;
    s        = '0;
    s[11:17] = m_pir;
    s[21:27] = m_pih;
    s[28]    = m_on;
    s[29:35] = m_pie;
    return s;
  endfunction

  function automatic logic [0:35] mk_dp(input bit b23, input bit b24, input bit b25,
                                        input bit b26, input bit b27, input bit b28,
                                        input bit [1:7] l);
    logic [0:35] d;
    d        = '0;
    d[23]    = b23;
    d[24]    = b24;
    d[25]    = b25;
    d[26]    = b26;
    d[27]    = b27;
    d[28]    = b28;
    d[29:35] = l;
    return d;
  endfunction

  task automatic model_reset();
    m_on = 0; m_pie = '0; m_pir = '0; m_pih = '0; m_req = 0; m_lev = 0;
  endtask

  // One enabled edge of the PI system, using inputs as they stand.
  task automatic model_step();
    bit [1:7] l;
    int b, h, lev;
    bit ack_now;
    if (clken !== 1'b1) return;
    l       = dp[29:35];
    b       = best_eligible();
    ack_now = m_req && pi_ack;
    lev     = m_lev;
    if (pi_cono && dp[23]) begin
      model_reset();
      return;
    end
    if (pi_dismiss) begin
      h = lowest(m_pih);
      if (h != 0) m_pih[h] = 0;
    end
    if (pi_cono && dp[24]) m_pir |= l;
    if (pi_cono && dp[26])      m_pie &= ~l;
    else if (pi_cono && dp[25]) m_pie |= l;
    if (pi_cono && dp[27])      m_on = 0;
    else if (pi_cono && dp[28]) m_on = 1;
    if (ack_now) begin
      m_pih[lev] = 1;
      m_pir[lev] = 0;
      m_req = 0; m_lev = 0;
    end else if (b != 0) begin
      m_req = 1; m_lev = b;
    end else begin
      m_req = 0; m_lev = 0;
    end
  endtask

  task automatic cycle();
    logic [2:0] el;
    @(posedge clk);
    model_step();
    #1;
    el = 3'(m_lev);
    check("int_req", 36'(pi_int_req), 36'(m_req));
    check("new_lev", 36'(pi_new_lev), 36'(el));
    check("pi_stat", pi_stat, exp_stat());
  endtask

  task automatic clear_ctl();
    pi_cono = 0; pi_ack = 0; pi_dismiss = 0; dp = '0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_req", 36'(pi_int_req), 36'd0);
    check("rst_lev", 36'(pi_new_lev), 36'd0);
    check("rst_stat", pi_stat, 36'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; bus_pi_req_in = '0;
    clear_ctl();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 36'(pi_int_req), 36'd0);
    check("reset_lev", 36'(pi_new_lev), 36'd0);
    check("reset_stat", pi_stat, 36'd0);
    rst = 1'b0;

    // PI ON plus enable level 5, then device request on level 5
    pi_cono = 1; dp = mk_dp(0, 0, 1, 0, 0, 1, 7'b0000100); cycle(); clear_ctl();
    bus_pi_req_in[5] = 1; cycle();
    check("req5", 36'(pi_int_req), 36'd1);
    check("lev5", 36'(pi_new_lev), 36'd5);
    pi_ack = 1; cycle(); clear_ctl();
    check("ack5_req", 36'(pi_int_req), 36'd0);
    check("pih5", 36'(pi_stat[25]), 36'd1);

    // Enable all levels; level 6 is held off by PIH 5, level 3 is not
    pi_cono = 1; dp = mk_dp(0, 0, 1, 0, 0, 0, 7'h7f); cycle(); clear_ctl();
    bus_pi_req_in[6] = 1; cycle(); cycle();
    check("hold6", 36'(pi_int_req), 36'd0);
    bus_pi_req_in[3] = 1; cycle();
    check("lev3", 36'(pi_new_lev), 36'd3);
    pi_ack = 1; cycle(); clear_ctl();
    bus_pi_req_in[3] = 0; pi_dismiss = 1; cycle();
    check("dis1_pih3", 36'(pi_stat[23]), 36'd0);
    check("dis1_pih5", 36'(pi_stat[25]), 36'd1);
    bus_pi_req_in = '0; cycle();
    check("dis2_pih5", 36'(pi_stat[25]), 36'd0);
    clear_ctl(); cycle();

    // Presented level rises in priority, then withdraws
    bus_pi_req_in[5] = 1; cycle();
    check("pres5", 36'(pi_new_lev), 36'd5);
    bus_pi_req_in[2] = 1; cycle();
    check("rise2", 36'(pi_new_lev), 36'd2);
    bus_pi_req_in = '0; cycle();
    check("withdraw", 36'(pi_int_req), 36'd0);

    // Program request on level 7 with all enables off
    pi_cono = 1; dp = mk_dp(0, 0, 0, 1, 0, 0, 7'h7f); cycle(); clear_ctl();
    pi_cono = 1; dp = mk_dp(0, 1, 0, 0, 0, 0, 7'b0000001); cycle(); clear_ctl();
    cycle();
    check("lev7", 36'(pi_new_lev), 36'd7);
    pi_ack = 1; cycle(); clear_ctl();
    check("pir7_clr", 36'(pi_stat[17]), 36'd0);
    pi_dismiss = 1; cycle(); clear_ctl();

    // Ack coincident with CONO clear-all
    pi_cono = 1; dp = mk_dp(0, 1, 0, 0, 0, 0, 7'b0001000); cycle(); clear_ctl();
    cycle();
    check("lev4", 36'(pi_new_lev), 36'd4);
    pi_ack = 1; pi_cono = 1; dp = mk_dp(1, 0, 0, 0, 0, 0, 7'h7f); cycle(); clear_ctl();
    check("clr_stat", pi_stat, 36'd0);
    check("clr_req", 36'(pi_int_req), 36'd0);

    // Set and clear enables together: clear wins
    pi_cono = 1; dp = mk_dp(0, 0, 1, 1, 0, 1, 7'h7f); cycle(); clear_ctl();
    check("pie_clr", 36'(pi_stat[29:35]), 36'd0);
    check("pi_on", 36'(pi_stat[28]), 36'd1);

    // Frozen by clken, then asynchronous reset mid-handshake
    pi_cono = 1; dp = mk_dp(0, 1, 0, 0, 0, 0, 7'b1000000); cycle(); clear_ctl();
    cycle();
    clken = 0; pi_ack = 1; cycle(); cycle();
    check("frz_req", 36'(pi_int_req), 36'd1);
    check("frz_lev", 36'(pi_new_lev), 36'd1);
    async_reset();
    clear_ctl(); clken = 1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clken         = ($urandom % 5) != 0;
      bus_pi_req_in = 7'($urandom);
      pi_cono       = ($urandom % 6) == 0;
      dp            = mk_dp(($urandom % 20) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                            ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 2) == 0,
                            7'($urandom));
      pi_ack        = ($urandom % 3) == 0;
      pi_dismiss    = ($urandom % 5) == 0;
      cycle();
      if (($urandom % 400) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
